hamming_enc_sched: RTL and testbench

Round-robin scheduler that shares one Hamming(7,4) encoder between N_REQ nibble producers. It accepts at most one 4-bit data word per cycle from the granted requester and encodes it combinationally. The 7-bit codeword is registered, tagged with its source index, and presented on a valid/ready output toward the channel/serializer stage. It also keeps a running count of delivered codewords.

---
 rtl/hamming_pkg.sv | 30 +++
 rtl/hamming_enc_sched_if.sv | 29 ++
 rtl/hamming_enc_sched_arb.sv | 42 ++++
 rtl/hamming_enc_sched.sv | 75 +++++++
 tb/tb_hamming_enc_sched.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: codeword geometry, bit positions and the encoder
// used by both the encoder scheduler and the decoder.
package hamming_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;

    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D3 = 2;
    localparam int P4 = 3;
    localparam int D5 = 4;
    localparam int D6 = 5;
    localparam int D7 = 6;

    // Data bits sit at classic Hamming positions 3,5,6,7; parity bits cover the positions they index.
    function automatic logic [CW_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] c;
        c     = '0;
        c[D3] = d[0];
        c[D5] = d[1];
        c[D6] = d[2];
        c[D7] = d[3];
        c[P1] = d[0] ^ d[1] ^ d[3];
        c[P2] = d[0] ^ d[2] ^ d[3];
        c[P4] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

endpackage

// File: rtl/hamming_enc_sched_if.sv
// Requester-side and codeword-side buses of the shared Hamming encoder scheduler.
interface hamming_enc_sched_if
    import hamming_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int CNT_W = 16
);
    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0][DATA_W-1:0] req_data;
    logic [N_REQ-1:0]             req_ready;
    logic                         cw_valid;
    logic [CW_W-1:0]              cw_data;
    logic [SRC_W-1:0]             cw_src;
    logic                         cw_ready;
    logic [CNT_W-1:0]             cw_count;

    modport master (
        output req_valid, req_data, cw_ready,
        input  req_ready, cw_valid, cw_data, cw_src, cw_count
    );

    modport slave (
        input  req_valid, req_data, cw_ready,
        output req_ready, cw_valid, cw_data, cw_src, cw_count
    );

endinterface

// File: rtl/hamming_enc_sched_arb.sv
// Round-robin arbiter: search starts at the pointer and wraps; the pointer moves past the winner on advance.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int SRC_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [SRC_W-1:0] grant_idx,
    output logic             any
);

    logic [SRC_W-1:0] rr;
    int               idx;

    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr) + k;
            if (idx >= N) idx = idx - N;
            if (!any && req[SRC_W'(idx)]) begin
                any       = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
    end

    assign grant = any ? (N'(1) << grant_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= '0;
        end else if (advance) begin
            rr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/hamming_enc_sched.sv
// Shares one Hamming(7,4) encoder among N_REQ nibble producers via round-robin and a registered output.
// Optional bit-flip injection on the encoded word is enabled by defining HAMMING_ERR_INJECT_EN.
module hamming_enc_sched
    import hamming_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hamming_enc_sched_if.slave    bus
`ifdef HAMMING_ERR_INJECT_EN
    ,
    input  logic                  inj_en,
    input  logic [2:0]            inj_pos
`endif
);

    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] grant;
    logic [SRC_W-1:0] grant_idx;
    logic             any_req;
    logic             load;
    logic [CW_W-1:0]  enc;
    logic             cw_valid_q;
    logic [CW_W-1:0]  cw_data_q;
    logic [SRC_W-1:0] cw_src_q;
    logic [CNT_W-1:0] cw_count_q;

    rr_arbiter #(.N(N_REQ), .SRC_W(SRC_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .advance   (load),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    // The register may refill in the same cycle it drains; nothing is granted while reset is held.
    assign load          = !rst && any_req && (!cw_valid_q || bus.cw_ready);
    assign bus.req_ready = load ? grant : '0;

    always_comb begin
        enc = hamming_encode(bus.req_data[grant_idx]);
`ifdef HAMMING_ERR_INJECT_EN
        if (inj_en && inj_pos != 3'd7) enc[inj_pos] = ~enc[inj_pos];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_valid_q <= 1'b0;
            cw_data_q  <= '0;
            cw_src_q   <= '0;
            cw_count_q <= '0;
        end else begin
            if (cw_valid_q && bus.cw_ready) cw_count_q <= cw_count_q + CNT_W'(1);
            if (load) begin
                cw_valid_q <= 1'b1;
                cw_data_q  <= enc;
                cw_src_q   <= grant_idx;
            end else if (cw_valid_q && bus.cw_ready) begin
                cw_valid_q <= 1'b0;
            end
        end
    end

    assign bus.cw_valid = cw_valid_q;
    assign bus.cw_data  = cw_data_q;
    assign bus.cw_src   = cw_src_q;
    assign bus.cw_count = cw_count_q;

endmodule

// File: tb/tb_hamming_enc_sched.sv
// Bench for hamming_enc_sched (N_REQ=2, CNT_W=4): cycle model plus directed literal checks.
// Injection vectors run only when HAMMING_ERR_INJECT_EN is defined.
module tb_hamming_enc_sched;

    localparam int N_REQ = 2;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
`ifdef HAMMING_ERR_INJECT_EN
    logic       inj_en;
    logic [2:0] inj_pos;
`endif

    int total_checks;
    int passed_checks;

    hamming_enc_sched_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

    hamming_enc_sched #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus)
`ifdef HAMMING_ERR_INJECT_EN
        ,
        .inj_en  (inj_en),
        .inj_pos (inj_pos)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Encoder model built from Hamming positions: each parity position p collects data positions with bit p set.
    function automatic logic [6:0] model_encode(input logic [3:0] d);
        logic [7:1] pos;
        pos    = '0;
        pos[3] = d[0];
        pos[5] = d[1];
        pos[6] = d[2];
        pos[7] = d[3];
        for (int p = 3; p <= 7; p++)
            if (p != 4 && pos[p])
                for (int b = 1; b <= 4; b = b * 2)
                    if ((p & b) != 0) pos[b] = ~pos[b];
        return pos[7:1];
    endfunction

    function automatic int model_grant(input logic [N_REQ-1:0] v, input int rr);
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (rr + k) % N_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    logic             m_valid;
    logic [6:0]       m_data;
    int               m_src;
    logic [CNT_W-1:0] m_count;
    int               m_rr;

    always @(posedge clk or posedge rst) begin
        int g;
        logic [6:0] w;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_count = '0;
            m_rr    = 0;
        end else begin
            g = model_grant(bus.req_valid, m_rr);
            if (m_valid && bus.cw_ready) m_count = m_count + 1'b1;
            if (g >= 0 && (!m_valid || bus.cw_ready)) begin
                w = model_encode(bus.req_data[g]);
`ifdef HAMMING_ERR_INJECT_EN
                if (inj_en && inj_pos != 3'd7) w[inj_pos] = ~w[inj_pos];
`endif
                m_data  = w;
                m_src   = g;
                m_valid = 1'b1;
                m_rr    = (g + 1) % N_REQ;
            end else if (m_valid && bus.cw_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        int g;
        logic [N_REQ-1:0] exp_ready;
        g = model_grant(bus.req_valid, m_rr);
        exp_ready = (!rst && g >= 0 && (!m_valid || bus.cw_ready)) ? N_REQ'(1 << g) : '0;
        checkOutput("cyc_req_ready", 32'(bus.req_ready), 32'(exp_ready));
        checkOutput("cyc_cw_valid", 32'(bus.cw_valid), 32'(m_valid));
        checkOutput("cyc_cw_data", 32'(bus.cw_data), 32'(m_data));
        checkOutput("cyc_cw_src", 32'(bus.cw_src), 32'(m_src));
        checkOutput("cyc_cw_count", 32'(bus.cw_count), 32'(m_count));
    end

    task automatic applyStimulus(input logic [1:0] v, input logic [3:0] d0, input logic [3:0] d1,
                                 input logic rdy);
        bus.req_valid   = v;
        bus.req_data[0] = d0;
        bus.req_data[1] = d1;
        bus.cw_ready    = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] pat_v [12] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11,
                               2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00};
    logic       pat_r [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                               1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        rst = 1'b1;
`ifdef HAMMING_ERR_INJECT_EN
        inj_en  = 1'b0;
        inj_pos = 3'd7;
`endif
        applyStimulus(2'b00, 4'h0, 4'h0, 1'b0);

        checkOutput("model_enc_B", 32'(model_encode(4'hB)), 32'h55);
        checkOutput("model_enc_1", 32'(model_encode(4'h1)), 32'h07);
        checkOutput("model_enc_F", 32'(model_encode(4'hF)), 32'h7F);
        checkOutput("model_enc_C", 32'(model_encode(4'hC)), 32'h61);
        checkOutput("model_enc_3", 32'(model_encode(4'h3)), 32'h1E);

        #1;
        checkOutput("rst_cw_valid", 32'(bus.cw_valid), 32'h0);
        checkOutput("rst_cw_count", 32'(bus.cw_count), 32'h0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
        step();
        step();
        rst = 1'b0;

        // Single requester, one nibble per cycle, visible one cycle after acceptance.
        applyStimulus(2'b01, 4'hB, 4'h0, 1'b1);
        step();
        checkOutput("enc_B", 32'(bus.cw_data), 32'h55);
        checkOutput("enc_B_valid", 32'(bus.cw_valid), 32'h1);
        applyStimulus(2'b01, 4'h1, 4'h0, 1'b1);
        step();
        checkOutput("enc_1", 32'(bus.cw_data), 32'h07);
        applyStimulus(2'b01, 4'h0, 4'h0, 1'b1);
        step();
        checkOutput("enc_0", 32'(bus.cw_data), 32'h00);
        applyStimulus(2'b01, 4'hF, 4'h0, 1'b1);
        step();
        checkOutput("enc_F", 32'(bus.cw_data), 32'h7F);
        applyStimulus(2'b00, 4'h0, 4'h0, 1'b1);
        step();
        checkOutput("enc_count", 32'(bus.cw_count), 32'h4);
        checkOutput("enc_drained", 32'(bus.cw_valid), 32'h0);

        // Reset with a codeword pending: everything clears without waiting for a clock.
        applyStimulus(2'b01, 4'hB, 4'h0, 1'b0);
        step();
        checkOutput("pend_valid", 32'(bus.cw_valid), 32'h1);
        checkOutput("pend_data", 32'(bus.cw_data), 32'h55);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(bus.cw_valid), 32'h0);
        checkOutput("midrst_data", 32'(bus.cw_data), 32'h0);
        checkOutput("midrst_count", 32'(bus.cw_count), 32'h0);
        checkOutput("midrst_ready", 32'(bus.req_ready), 32'h0);
        applyStimulus(2'b00, 4'h0, 4'h0, 1'b0);
        step();
        rst = 1'b0;

        // Both requesters continuously valid: grants alternate starting at requester 0.
        applyStimulus(2'b11, 4'h3, 4'hC, 1'b1);
        step();
        checkOutput("fair0_src", 32'(bus.cw_src), 32'h0);
        checkOutput("fair0_data", 32'(bus.cw_data), 32'h1E);
        step();
        checkOutput("fair1_src", 32'(bus.cw_src), 32'h1);
        checkOutput("fair1_data", 32'(bus.cw_data), 32'h61);
        step();
        checkOutput("fair2_src", 32'(bus.cw_src), 32'h0);
        step();
        checkOutput("fair3_src", 32'(bus.cw_src), 32'h1);
        checkOutput("fair3_count", 32'(bus.cw_count), 32'h3);

        // Backpressure holds the codeword and blocks all grants.
        applyStimulus(2'b11, 4'h3, 4'hC, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("bp_req_ready", 32'(bus.req_ready), 32'h0);
            checkOutput("bp_data", 32'(bus.cw_data), 32'h61);
        end
        applyStimulus(2'b11, 4'h3, 4'hC, 1'b1);
        #1;
        checkOutput("release_ready", 32'(bus.req_ready), 32'h1);
        step();
        checkOutput("release_valid", 32'(bus.cw_valid), 32'h1);
        checkOutput("release_data", 32'(bus.cw_data), 32'h1E);
        checkOutput("release_count", 32'(bus.cw_count), 32'h4);
        applyStimulus(2'b00, 4'h0, 4'h0, 1'b1);
        step();

        // Mixed valid/ready pattern, checked by the cycle model.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(pat_v[i], 4'(i), 4'(15 - i), pat_r[i]);
            step();
        end
        applyStimulus(2'b00, 4'h0, 4'h0, 1'b1);
        step();
        step();

        // 17 handshakes on a 4-bit counter wrap it to 1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(2'b01, 4'(i), 4'h0, 1'b1);
            step();
        end
        applyStimulus(2'b00, 4'h0, 4'h0, 1'b1);
        step();
        checkOutput("wrap_count", 32'(bus.cw_count), 32'h1);

`ifdef HAMMING_ERR_INJECT_EN
        applyStimulus(2'b01, 4'hB, 4'h0, 1'b1);
        inj_en  = 1'b1;
        inj_pos = 3'd3;
        step();
        checkOutput("inj_pos3", 32'(bus.cw_data), 32'h5D);
        inj_pos = 3'd7;
        step();
        checkOutput("inj_pos7", 32'(bus.cw_data), 32'h55);
        inj_en = 1'b0;
        applyStimulus(2'b00, 4'h0, 4'h0, 1'b1);
        step();
`endif

        step();
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
